// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller.
// States, opcode/funct constants, datapath mux codes and the control bundle.
package mc_pkg;

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_FWAIT, S_IRLD, S_DECODE,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_ADDR, S_MRD, S_MWAIT, S_MLD, S_WB_L, S_MWR,
    S_BRANCH, S_JUMP, S_HALT, S_EXC, S_EXCJ
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_BREAK = 6'b001101;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_PASSB = 3'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_EXC    = 2'd3;

  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_A   = 2'd1;
  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_BR  = 2'd3;

  localparam logic [1:0] EXC_ILL = 2'd0;
  localparam logic [1:0] EXC_OVF = 2'd1;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] iord;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_write;
    logic       a_write;
    logic       b_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       aluout_write;
    logic [1:0] pc_source;
    logic       epc_write;
    logic [1:0] exc_sel;
  } ctl_t;

endpackage

// File: rtl/mc_wait_cnt.sv
// Loadable down-counter timing memory wait states.
// done flags an empty counter; last flags the final decrement.
module mc_wait_cnt #(
  parameter int MAX = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done,
  output logic last
);

  localparam int CW = (MAX > 0) ? $clog2(MAX + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MAX);
    end else if (dec && !done) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);
  assign last = (cnt == CW'(1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM with memory waits and exceptions.
// Outputs are registered from the next state so they always track state.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int OVF_TRAP = 1,
  parameter int ST_W     = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            overflow,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            branch_ne,
  output logic [1:0]      iord,
  output logic            mem_wr,
  output logic            ir_write,
  output logic            mdr_write,
  output logic            a_write,
  output logic            b_write,
  output logic            reg_write,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_op,
  output logic            aluout_write,
  output logic [1:0]      pc_source,
  output logic            epc_write,
  output logic [1:0]      exc_sel,
  output logic [ST_W-1:0] state
);

  state_t st, ns;
  ctl_t ctl, nx;
  logic [2:0] r_aop, n_aop;
  logic [1:0] r_exc, n_exc;
  logic r_bne, n_bne;
  logic r_chk, n_chk;
  logic r_lw, n_lw;
  logic ld, dec, done, last, trap;

  mc_wait_cnt #(.MAX(MEM_WAIT)) u_wait (
    .clock(clock),
    .reset(reset),
    .load(ld),
    .dec(dec),
    .done(done),
    .last(last)
  );

  assign trap = (OVF_TRAP != 0) && r_chk && overflow;

  always_comb begin
    ns = st;
    n_aop = r_aop;
    n_exc = r_exc;
    n_bne = r_bne;
    n_chk = r_chk;
    n_lw = r_lw;
    ld = 1'b0;
    dec = 1'b0;
    unique case (st)
      S_RST: ns = S_FETCH;
      S_FETCH: begin
        ld = 1'b1;
        ns = (MEM_WAIT == 0) ? S_IRLD : S_FWAIT;
      end
      S_FWAIT: begin
        dec = 1'b1;
        if (last || done) ns = S_IRLD;
      end
      S_IRLD: ns = S_DECODE;
      S_DECODE: begin
        n_chk = 1'b0;
        n_exc = EXC_ILL;
        ns = S_EXC;
        case (opcode)
          OP_R: begin
            case (funct)
              FN_ADD: begin
                ns = S_EXEC_R; n_aop = ALU_ADD; n_chk = 1'b1;
              end
              FN_SUB: begin
                ns = S_EXEC_R; n_aop = ALU_SUB; n_chk = 1'b1;
              end
              FN_AND: begin
                ns = S_EXEC_R; n_aop = ALU_AND;
              end
              FN_BREAK: ns = S_HALT;
              default: ns = S_EXC;
            endcase
          end
          OP_ADDI: begin
            ns = S_EXEC_I; n_chk = 1'b1;
          end
          OP_ADDIU: ns = S_EXEC_I;
          OP_LW: begin
            ns = S_ADDR; n_lw = 1'b1;
          end
          OP_SW: begin
            ns = S_ADDR; n_lw = 1'b0;
          end
          OP_BEQ: begin
            ns = S_BRANCH; n_bne = 1'b0;
          end
          OP_BNE: begin
            ns = S_BRANCH; n_bne = 1'b1;
          end
          OP_J: ns = S_JUMP;
          default: ns = S_EXC;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        if (trap) begin
          ns = S_EXC; n_exc = EXC_OVF;
        end else begin
          ns = (st == S_EXEC_R) ? S_WB_R : S_WB_I;
        end
      end
      S_ADDR: ns = r_lw ? S_MRD : S_MWR;
      S_MRD: begin
        ld = 1'b1;
        ns = (MEM_WAIT == 0) ? S_MLD : S_MWAIT;
      end
      S_MWAIT: begin
        dec = 1'b1;
        if (last || done) ns = S_MLD;
      end
      S_MLD: ns = S_WB_L;
      S_EXC: ns = S_EXCJ;
      S_HALT: ns = S_HALT;
      S_WB_R, S_WB_I, S_WB_L, S_MWR,
      S_BRANCH, S_JUMP, S_EXCJ: ns = S_FETCH;
      default: ns = S_RST;
    endcase
  end

  always_comb begin
    nx = '0;
    unique case (ns)
      S_FETCH: begin
        nx.pc_write = 1'b1;
        nx.alu_src_b = SRCB_4;
        nx.pc_source = PCS_ALU;
      end
      S_IRLD: nx.ir_write = 1'b1;
      S_DECODE: begin
        nx.a_write = 1'b1;
        nx.b_write = 1'b1;
        nx.alu_src_b = SRCB_BR;
        nx.aluout_write = 1'b1;
      end
      S_EXEC_R: begin
        nx.alu_src_a = SRCA_A;
        nx.alu_src_b = SRCB_B;
        nx.alu_op = n_aop;
        nx.aluout_write = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        nx.alu_src_a = SRCA_A;
        nx.alu_src_b = SRCB_IMM;
        nx.aluout_write = 1'b1;
      end
      S_WB_R: begin
        nx.reg_write = 1'b1;
        nx.reg_dst = 2'd1;
      end
      S_WB_I: nx.reg_write = 1'b1;
      S_MRD: nx.iord = 2'd1;
      S_MLD: nx.mdr_write = 1'b1;
      S_WB_L: begin
        nx.reg_write = 1'b1;
        nx.mem_to_reg = 2'd1;
      end
      S_MWR: begin
        nx.iord = 2'd1;
        nx.mem_wr = 1'b1;
      end
      S_BRANCH: begin
        nx.alu_src_a = SRCA_A;
        nx.alu_op = ALU_SUB;
        nx.pc_write_cond = 1'b1;
        nx.pc_source = PCS_ALUOUT;
        nx.branch_ne = n_bne;
      end
      S_JUMP: begin
        nx.pc_write = 1'b1;
        nx.pc_source = PCS_JUMP;
      end
      S_EXC: begin
        nx.epc_write = 1'b1;
        nx.alu_src_b = SRCB_4;
        nx.alu_op = ALU_SUB;
        nx.exc_sel = n_exc;
      end
      S_EXCJ: begin
        nx.pc_write = 1'b1;
        nx.pc_source = PCS_EXC;
        nx.exc_sel = n_exc;
      end
      default: nx = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= S_RST;
      ctl <= '0;
      r_aop <= '0;
      r_exc <= '0;
      r_bne <= 1'b0;
      r_chk <= 1'b0;
      r_lw <= 1'b0;
    end else begin
      st <= ns;
      ctl <= nx;
      r_aop <= n_aop;
      r_exc <= n_exc;
      r_bne <= n_bne;
      r_chk <= n_chk;
      r_lw <= n_lw;
    end
  end

  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign branch_ne     = ctl.branch_ne;
  assign iord          = ctl.iord;
  assign mem_wr        = ctl.mem_wr;
  assign ir_write      = ctl.ir_write;
  assign mdr_write     = ctl.mdr_write;
  assign a_write       = ctl.a_write;
  assign b_write       = ctl.b_write;
  assign reg_write     = ctl.reg_write;
  assign reg_dst       = ctl.reg_dst;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign aluout_write  = ctl.aluout_write;
  assign pc_source     = ctl.pc_source;
  assign epc_write     = ctl.epc_write;
  assign exc_sel       = ctl.exc_sel;
  assign state         = ST_W'(st);

endmodule
